// File: rtl/pid_controller.sv
// Discrete-time PID controller, one update per clock, two-stage pipeline.
// Ports: clk, reset_n (async low), sensor_measurment, setpoint,
//   Kp/Ki/Kd (signed Q8.8 gains), y_out (saturated signed output).
module pid_controller #(
   parameter int W       = 16,
   parameter int MAX_VAL = 32767,
   parameter int MIN_VAL = -32768
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [W-1:0] sensor_measurment,
   input  logic [W-1:0] setpoint,
   input  logic [W-1:0] Kp,
   input  logic [W-1:0] Ki,
   input  logic [W-1:0] Kd,
   output logic [W-1:0] y_out
);

   localparam int AW = 2*W+2;

   localparam logic signed [W:0]    MAX1 = (W+1)'(MAX_VAL);
   localparam logic signed [W:0]    MIN1 = (W+1)'(MIN_VAL);
   localparam logic signed [AW-1:0] MAXA = AW'(MAX_VAL);
   localparam logic signed [AW-1:0] MINA = AW'(MIN_VAL);
   localparam logic signed [W-1:0]  MAXW = W'(MAX_VAL);
   localparam logic signed [W-1:0]  MINW = W'(MIN_VAL);

   function automatic logic signed [W-1:0] sat1(
      input logic signed [W:0] v
   );
      if (v > MAX1)
         return MAXW;
      else if (v < MIN1)
         return MINW;
      else
         return v[W-1:0];
   endfunction

   function automatic logic signed [W-1:0] sata(
      input logic signed [AW-1:0] v
   );
      if (v > MAXA)
         return MAXW;
      else if (v < MINA)
         return MINW;
      else
         return v[W-1:0];
   endfunction

   logic signed [W-1:0]    r_e;
   logic signed [W-1:0]    r_d;
   logic signed [W-1:0]    r_i;
   logic signed [W-1:0]    r_y;

   logic signed [W:0]      w_err_raw;
   logic signed [W-1:0]    w_err;
   logic signed [W:0]      w_d_raw;
   logic signed [W:0]      w_i_raw;
   logic signed [2*W-1:0]  w_pp;
   logic signed [2*W-1:0]  w_pi;
   logic signed [2*W-1:0]  w_pd;
   logic signed [AW-1:0]   w_acc;
   logic signed [AW-1:0]   w_sh;

   // Stage 1: error and its running sum / difference, all in W+1 bits.
   assign w_err_raw = $signed({setpoint[W-1], setpoint})
                    - $signed({sensor_measurment[W-1],
                               sensor_measurment});
   assign w_err     = sat1(w_err_raw);
   assign w_d_raw   = $signed({w_err[W-1], w_err})
                    - $signed({r_e[W-1], r_e});
   assign w_i_raw   = $signed({r_i[W-1], r_i})
                    + $signed({w_err[W-1], w_err});

   // Stage 2: gains enter unregistered; 2 guard bits make the sum exact.
   assign w_pp  = $signed(Kp) * r_e;
   assign w_pi  = $signed(Ki) * r_i;
   assign w_pd  = $signed(Kd) * r_d;
   assign w_acc = $signed({{2{w_pp[2*W-1]}}, w_pp})
                + $signed({{2{w_pi[2*W-1]}}, w_pi})
                + $signed({{2{w_pd[2*W-1]}}, w_pd});
   // Arithmetic shift floors toward minus infinity.
   assign w_sh  = w_acc >>> 8;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_e <= '0;
         r_d <= '0;
         r_i <= '0;
         r_y <= '0;
      end else begin
         r_e <= w_err;
         r_d <= sat1(w_d_raw);
         r_i <= sat1(w_i_raw);
         r_y <= sata(w_sh);
      end
   end

   assign y_out = r_y;

endmodule

// File: tb/tb_pid_controller.sv
// Self-checking bench for pid_controller: vector table
// plus multi-cycle sequences and a closed-loop plant run.
module tb_pid_controller;

   logic        clk;
   logic        reset_n;
   logic [15:0] sensor_measurment;
   logic [15:0] setpoint;
   logic [15:0] Kp;
   logic [15:0] Ki;
   logic [15:0] Kd;
   logic [15:0] y_out;

   int n_vec;
   int n_err;

   pid_controller dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .sensor_measurment (sensor_measurment),
      .setpoint          (setpoint),
      .Kp                (Kp),
      .Ki                (Ki),
      .Kd                (Kd),
      .y_out             (y_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string name;
      int    sp;
      int    meas;
      int    kp;
      int    ki;
      int    kd;
      int    exp_y;
   } vec_t;

   vec_t tbl[13];

   task automatic check(input string nm, input int exp_v);
      int got;
      got = $signed(y_out);
      n_vec++;
      if (got != exp_v) begin
         n_err++;
         $display("FAIL %s: y_out=%0d expected %0d", nm, got, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input int sp, input int m, input int kp,
                         input int ki, input int kd);
      setpoint          = 16'(sp);
      sensor_measurment = 16'(m);
      Kp                = 16'(kp);
      Ki                = 16'(ki);
      Kd                = 16'(kd);
   endtask

   // Async reset pulse placed between clock edges.
   task automatic do_reset();
      tick();
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
   endtask

   int   x100;
   int   meas;
   bit   reached;

   initial begin
      n_vec = 0;
      n_err = 0;
      reset_n = 1'b0;
      set_in(0, 0, 0, 0, 0);

      tbl[0]  = '{"p_unity",     1000,      0,   256,   0,   0,  1000};
      tbl[1]  = '{"p_frac_pos",  1000,      0,   300,   0,   0,  1171};
      tbl[2]  = '{"p_frac_neg",     0,   1000,   300,   0,   0, -1172};
      tbl[3]  = '{"p_diff_only", 5000,   4000,   256,   0,   0,  1000};
      tbl[4]  = '{"err_sat_hi", 32767, -32768,   256,   0,   0, 32767};
      tbl[5]  = '{"err_sat_lo",-32768,  32767,   256,   0,   0,-32768};
      tbl[6]  = '{"out_sat_hi",32767,       0, 32767,   0,   0, 32767};
      tbl[7]  = '{"out_sat_lo",-32768,      0, 32767,   0,   0,-32768};
      tbl[8]  = '{"zero_gains",  1000,      0,     0,   0,   0,     0};
      tbl[9]  = '{"pid_mix",       10,      0,   256, 256, 256,    30};
      tbl[10] = '{"neg_gain",    1000,      0,  -256,   0,   0, -1000};
      tbl[11] = '{"floor_half",    -3,      0,   128,   0,   0,    -2};
      tbl[12] = '{"i_neg",         -7,      0,     0, 256,   0,   -14};

      #3;
      check("reset_state", 0);
      #4;
      reset_n = 1'b1;

      // Each vector: fresh reset, hold inputs for 3 edges, then compare.
      foreach (tbl[k]) begin
         do_reset();
         set_in(tbl[k].sp, tbl[k].meas, tbl[k].kp,
                tbl[k].ki, tbl[k].kd);
         for (int c = 0; c < 3; c++) tick();
         check(tbl[k].name, tbl[k].exp_y);
      end

      // Two-edge latency of the P path.
      do_reset();
      set_in(1000, 0, 256, 0, 0);
      tick();
      check("lat_edge1", 0);
      tick();
      check("lat_edge2", 1000);

      // Derivative: one-cycle pulse, first cycle uses e_r = 0.
      do_reset();
      set_in(0, 0, 0, 0, 256);
      tick();
      setpoint = 16'd1000;
      tick();
      check("d_edge1", 0);
      tick();
      check("d_pulse", 1000);
      tick();
      check("d_after", 0);

      // Integral ramp.
      do_reset();
      set_in(10, 0, 0, 256, 0);
      tick();
      tick();
      check("i_ramp1", 10);
      tick();
      check("i_ramp2", 20);
      tick();
      check("i_ramp3", 30);

      // Integral clamp and immediate unwind.
      do_reset();
      set_in(30000, 0, 0, 256, 0);
      tick();
      tick();
      check("i_big", 30000);
      tick();
      check("i_clamp", 32767);
      for (int c = 0; c < 4; c++) tick();
      check("i_hold", 32767);
      setpoint = 16'(-100);
      tick();
      tick();
      check("i_unwind1", 32667);
      tick();
      check("i_unwind2", 32567);

      // Asynchronous reset mid-operation.
      do_reset();
      set_in(10, 0, 0, 256, 0);
      for (int c = 0; c < 5; c++) tick();
      check("pre_reset", 40);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_clear", 0);
      #1;
      reset_n = 1'b1;
      tick();
      check("post_rst_e1", 0);
      tick();
      check("post_rst_e2", 10);

      // Closed loop against an integrating plant, x += 0.01*y.
      do_reset();
      set_in(1000, 0, 300, 10, 50);
      x100 = 0;
      reached = 1'b0;
      for (int c = 0; c < 1000; c++) begin
         meas = x100 / 100;
         sensor_measurment = 16'(meas);
         if (meas >= 950 && meas <= 1050) reached = 1'b1;
         tick();
         x100 = x100 + $signed(y_out);
      end
      n_vec++;
      if (!reached) begin
         n_err++;
         $display("FAIL closed_loop: meas=%0d expected 950..1050",
                  meas);
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
